// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer, display and ball datapath:
// state encoding, brick wall geometry and brick addressing.
package game_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'b00,
        ST_PLAY  = 2'b01,
        ST_OVER  = 2'b10,
        ST_WIN   = 2'b11
    } game_state_t;

    localparam int BRICK_ROWS = 2;
    localparam int BRICK_COLS = 8;

    localparam logic [2:0] BRICK_Y_LO = 3'd6;
    localparam logic [2:0] BRICK_Y_HI = 3'd7;

    // Row y=7 maps to bits [15:8], row y=6 to bits [7:0]; column is the bit offset.
    function automatic logic [3:0] brick_index(input logic [2:0] x, input logic [2:0] y);
        return {y[0], x};
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Sequencer <-> ball datapath / display signal bundle.
interface game_sequencer_if;

    logic        throw;
    logic [2:0]  ball_x;
    logic [2:0]  ball_y;
    logic        ball_miss;

    logic        ball_step;
    logic        hold_ball;
    logic        ball_reload;
    logic        bounce_down;
    logic [15:0] brick_map;
    logic [1:0]  lives;
    logic [4:0]  score;
    logic [1:0]  state;

    // Sequencer side.
    modport master (
        input  throw, ball_x, ball_y, ball_miss,
        output ball_step, hold_ball, ball_reload, bounce_down,
               brick_map, lives, score, state
    );

    // Datapath / environment side.
    modport slave (
        output throw, ball_x, ball_y, ball_miss,
        input  ball_step, hold_ball, ball_reload, bounce_down,
               brick_map, lives, score, state
    );

endinterface

// File: rtl/game_sequencer_step_timer.sv
// Programmable ball-step divider. Inputs describe the upcoming cycle so the
// tick can be produced straight from a register: o_tick is high in the cycle
// whose count equals div-1, giving a period of exactly div cycles.
module step_timer (
    input  logic       buttonclk,
    input  logic       reset,
    input  logic [2:0] i_div,
    input  logic       i_clear,
    input  logic       i_enable,
    output logic       o_tick
);

    logic [2:0] r_cnt_reg;
    logic [2:0] w_cnt_next;
    logic       r_tick_reg;
    logic       w_tick_next;

    // Next count wraps after a tick; '>=' keeps the wrap safe when div shrinks.
    always_comb begin
        w_cnt_next  = r_tick_reg ? 3'd0 : (r_cnt_reg + 3'd1);
        if (i_clear || !i_enable) begin
            w_cnt_next = 3'd0;
        end
        w_tick_next = i_enable && (w_cnt_next >= (i_div - 3'd1));
    end

    // Counter and registered tick.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_cnt_reg  <= 3'd0;
            r_tick_reg <= 1'b0;
        end else begin
            r_cnt_reg  <= w_cnt_next;
            r_tick_reg <= w_tick_next;
        end
    end

    assign o_tick = r_tick_reg;

endmodule

// File: rtl/game_sequencer.sv
// Breakout-style game sequencer: serve/play/over/win control, brick wall,
// lives, score and progressive ball speed-up. All outputs come from registers.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int STEP_DIV_INIT = 3,
    parameter int STEP_DIV_MIN  = 1,
    parameter int SPEEDUP_EVERY = 4
) (
    input  logic             buttonclk,
    input  logic             reset,
    game_sequencer_if.master bus
);

    localparam logic [1:0] LIVES_INIT   = 2'(LIVES);
    localparam logic [2:0] DIV_INIT     = 3'(STEP_DIV_INIT);
    localparam logic [2:0] DIV_MIN      = 3'(STEP_DIV_MIN);
    localparam logic [4:0] SPEEDUP_LAST = 5'(SPEEDUP_EVERY - 1);

    game_state_t r_state_reg, w_state_next;
    logic [15:0] r_bricks_reg, w_bricks_next;
    logic [1:0]  r_lives_reg, w_lives_next;
    logic [4:0]  r_score_reg, w_score_next;
    logic [4:0]  r_speed_cnt_reg, w_speed_cnt_next;
    logic [2:0]  r_div_reg, w_div_next;
    logic        r_hold_reg, w_hold_next;
    logic        r_reload_reg, w_reload_next;
    logic        r_bounce_reg, w_bounce_next;
    logic        r_throw_prev_reg;
    logic        r_step_d_reg;

    logic        w_throw_edge;
    logic        w_clear;
    logic        w_hit;
    logic        w_tick;
    logic [3:0]  w_brick_idx;

    assign w_throw_edge = bus.throw && !r_throw_prev_reg;
    assign w_brick_idx  = brick_index(bus.ball_x, bus.ball_y);
    // A hit is only evaluated in the cycle right after a step, so one step yields at most one hit.
    assign w_hit = (r_state_reg == ST_PLAY) && r_step_d_reg
                && ((bus.ball_y == BRICK_Y_LO) || (bus.ball_y == BRICK_Y_HI))
                && r_bricks_reg[w_brick_idx];

    // Next-state and next-output logic for the game FSM.
    always_comb begin
        w_state_next     = r_state_reg;
        w_bricks_next    = r_bricks_reg;
        w_lives_next     = r_lives_reg;
        w_score_next     = r_score_reg;
        w_speed_cnt_next = r_speed_cnt_reg;
        w_div_next       = r_div_reg;
        w_reload_next    = 1'b0;
        w_bounce_next    = 1'b0;
        w_clear          = 1'b0;

        case (r_state_reg)
            ST_SERVE: begin
                if (w_throw_edge) begin
                    w_state_next = ST_PLAY;
                    w_clear      = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_hit) begin
                    w_bricks_next[w_brick_idx] = 1'b0;
                    w_score_next  = r_score_reg + 5'd1;
                    w_bounce_next = 1'b1;
                    if (r_speed_cnt_reg == SPEEDUP_LAST) begin
                        w_speed_cnt_next = 5'd0;
                        if (r_div_reg > DIV_MIN) begin
                            w_div_next = r_div_reg - 3'd1;
                        end
                    end else begin
                        w_speed_cnt_next = r_speed_cnt_reg + 5'd1;
                    end
                end
                // Clearing the wall wins even if the ball is lost in the same cycle.
                if (w_hit && (w_bricks_next == 16'h0000)) begin
                    w_state_next = ST_WIN;
                end else if (bus.ball_miss) begin
                    w_lives_next = r_lives_reg - 2'd1;
                    if (r_lives_reg == 2'd1) begin
                        w_state_next = ST_OVER;
                    end else begin
                        w_state_next  = ST_SERVE;
                        w_reload_next = 1'b1;
                    end
                end
            end
            default: begin
                // OVER / WIN: a throw restarts a fresh game.
                if (w_throw_edge) begin
                    w_state_next     = ST_SERVE;
                    w_bricks_next    = 16'hFFFF;
                    w_lives_next     = LIVES_INIT;
                    w_score_next     = 5'd0;
                    w_speed_cnt_next = 5'd0;
                    w_div_next       = DIV_INIT;
                    w_reload_next    = 1'b1;
                end
            end
        endcase

        w_hold_next = (w_state_next != ST_PLAY);
    end

    // State and game-data registers; reset overrides every event.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_state_reg      <= ST_SERVE;
            r_bricks_reg     <= 16'hFFFF;
            r_lives_reg      <= LIVES_INIT;
            r_score_reg      <= 5'd0;
            r_speed_cnt_reg  <= 5'd0;
            r_div_reg        <= DIV_INIT;
            r_hold_reg       <= 1'b1;
            r_reload_reg     <= 1'b0;
            r_bounce_reg     <= 1'b0;
            r_throw_prev_reg <= 1'b1;
            r_step_d_reg     <= 1'b0;
        end else begin
            r_state_reg      <= w_state_next;
            r_bricks_reg     <= w_bricks_next;
            r_lives_reg      <= w_lives_next;
            r_score_reg      <= w_score_next;
            r_speed_cnt_reg  <= w_speed_cnt_next;
            r_div_reg        <= w_div_next;
            r_hold_reg       <= w_hold_next;
            r_reload_reg     <= w_reload_next;
            r_bounce_reg     <= w_bounce_next;
            r_throw_prev_reg <= bus.throw;
            r_step_d_reg     <= w_tick;
        end
    end

    step_timer u_step_timer (
        .buttonclk (buttonclk),
        .reset     (reset),
        .i_div     (w_div_next),
        .i_clear   (w_clear),
        .i_enable  (w_state_next == ST_PLAY),
        .o_tick    (w_tick)
    );

    assign bus.ball_step   = w_tick;
    assign bus.hold_ball   = r_hold_reg;
    assign bus.ball_reload = r_reload_reg;
    assign bus.bounce_down = r_bounce_reg;
    assign bus.brick_map   = r_bricks_reg;
    assign bus.lives       = r_lives_reg;
    assign bus.score       = r_score_reg;
    assign bus.state       = r_state_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
module tb_game_sequencer;

    logic buttonclk = 1'b0;
    logic reset     = 1'b1;

    always #5 buttonclk = ~buttonclk;

    game_sequencer_if bus ();

    game_sequencer #(
        .LIVES         (3),
        .STEP_DIV_INIT (3),
        .STEP_DIV_MIN  (1),
        .SPEEDUP_EVERY (4)
    ) dut (
        .buttonclk (buttonclk),
        .reset     (reset),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge buttonclk);
        #1;
    endtask

    // Advance until a ball_step cycle is observed (bounded).
    task automatic wait_step();
        int n;
        n = 0;
        tick();
        while (!bus.ball_step && n < 20) begin
            tick();
            n++;
        end
        check("wait_step", 32'(bus.ball_step), 32'd1);
    endtask

    // Cycles between two consecutive ball_step strobes.
    task automatic measure_period(output int p);
        wait_step();
        p = 0;
        do begin
            tick();
            p++;
        end while (!bus.ball_step && p < 20);
    endtask

    // Present a brick position around a step so the following check cycle hits it.
    task automatic do_hit(input int x, input int y);
        wait_step();
        bus.ball_x = 3'(x);
        bus.ball_y = 3'(y);
        tick();
        tick();
        bus.ball_x = 3'd0;
        bus.ball_y = 3'd0;
    endtask

    // Hit order after the first brick (5,7): row 6 cols 0..7, then row 7 cols 0..4,6.
    task automatic hit_n(input int i);
        int col7 [6] = '{0, 1, 2, 3, 4, 6};
        if (i < 8) do_hit(i, 6);
        else       do_hit(col7[i-8], 7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int transitions;
        logic [9:0] pattern;

        bus.throw = 1'b1;
        bus.ball_x = 3'd0;
        bus.ball_y = 3'd0;
        bus.ball_miss = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state (throw held through reset)
        check("rst_state",  32'(bus.state), 32'h0);
        check("rst_bricks", 32'(bus.brick_map), 32'hFFFF);
        check("rst_lives",  32'(bus.lives), 32'd3);
        check("rst_score",  32'(bus.score), 32'd0);
        check("rst_hold",   32'(bus.hold_ball), 32'd1);
        check("rst_step",   32'(bus.ball_step), 32'd0);
        check("rst_reload", 32'(bus.ball_reload), 32'd0);
        check("rst_bounce", 32'(bus.bounce_down), 32'd0);
        tick();
        check("throw_thru_reset", 32'(bus.state), 32'h0);

        // Serve, then hold throw for 10 cycles
        bus.throw = 1'b0;
        tick();
        bus.throw = 1'b1;
        tick();
        check("serve_to_play", 32'(bus.state), 32'h1);
        check("play_hold", 32'(bus.hold_ball), 32'd0);
        pattern = '0;
        pattern[0] = bus.ball_step;
        transitions = 0;
        for (int k = 1; k < 10; k++) begin
            tick();
            pattern[k] = bus.ball_step;
            if (bus.state != 2'b01) transitions++;
        end
        check("step_pattern_div3", 32'(pattern), 32'h124);
        check("held_throw_transitions", 32'(transitions), 32'd0);
        bus.throw = 1'b0;

        // New throw edge in PLAY is ignored
        tick();
        bus.throw = 1'b1;
        tick();
        check("throw_in_play_ignored", 32'(bus.state), 32'h1);
        bus.throw = 1'b0;

        // First hit at (5,7) and no repeat hit at the same spot
        wait_step();
        bus.ball_x = 3'd5;
        bus.ball_y = 3'd7;
        tick();
        check("hit1_bounce_early", 32'(bus.bounce_down), 32'd0);
        tick();
        check("hit1_bricks", 32'(bus.brick_map), 32'hDFFF);
        check("hit1_score",  32'(bus.score), 32'd1);
        check("hit1_bounce", 32'(bus.bounce_down), 32'd1);
        tick();
        check("hit1_bounce_off", 32'(bus.bounce_down), 32'd0);
        tick();
        tick();
        check("rehit_score",  32'(bus.score), 32'd1);
        check("rehit_bricks", 32'(bus.brick_map), 32'hDFFF);
        check("rehit_bounce", 32'(bus.bounce_down), 32'd0);
        bus.ball_x = 3'd0;
        bus.ball_y = 3'd0;
        measure_period(p);
        check("period_score1", 32'(p), 32'd3);

        // Speed-up every 4 bricks, saturating at 1
        for (int i = 0; i < 3; i++) hit_n(i);
        check("score4", 32'(bus.score), 32'd4);
        measure_period(p);
        check("period_score4", 32'(p), 32'd2);
        for (int i = 3; i < 7; i++) hit_n(i);
        check("score8", 32'(bus.score), 32'd8);
        measure_period(p);
        check("period_score8", 32'(p), 32'd1);
        for (int i = 7; i < 11; i++) hit_n(i);
        check("score12", 32'(bus.score), 32'd12);
        measure_period(p);
        check("period_score12", 32'(p), 32'd1);
        for (int i = 11; i < 14; i++) hit_n(i);
        check("score15", 32'(bus.score), 32'd15);
        check("bricks15", 32'(bus.brick_map), 32'h8000);

        // Last brick with simultaneous miss (div=1: every cycle is a check cycle)
        wait_step();
        bus.ball_x = 3'd7;
        bus.ball_y = 3'd7;
        bus.ball_miss = 1'b1;
        tick();
        bus.ball_miss = 1'b0;
        bus.ball_x = 3'd0;
        bus.ball_y = 3'd0;
        check("win_state",  32'(bus.state), 32'h3);
        check("win_lives",  32'(bus.lives), 32'd3);
        check("win_score",  32'(bus.score), 32'd16);
        check("win_bricks", 32'(bus.brick_map), 32'h0);
        check("win_reload", 32'(bus.ball_reload), 32'd0);
        repeat (3) tick();
        check("win_no_step", 32'(bus.ball_step), 32'd0);
        check("win_hold",    32'(bus.hold_ball), 32'd1);
        bus.ball_miss = 1'b1;
        tick();
        bus.ball_miss = 1'b0;
        check("miss_in_win_ignored", 32'(bus.lives), 32'd3);

        // Restart from WIN, throw held afterwards
        bus.throw = 1'b1;
        tick();
        check("restart_state",  32'(bus.state), 32'h0);
        check("restart_bricks", 32'(bus.brick_map), 32'hFFFF);
        check("restart_score",  32'(bus.score), 32'd0);
        check("restart_reload", 32'(bus.ball_reload), 32'd1);
        tick();
        check("restart_reload_off", 32'(bus.ball_reload), 32'd0);
        check("restart_held_throw", 32'(bus.state), 32'h0);
        bus.throw = 1'b0;
        tick();
        bus.throw = 1'b1;
        tick();
        bus.throw = 1'b0;
        measure_period(p);
        check("period_after_restart", 32'(p), 32'd3);

        // Lives: three misses
        bus.ball_miss = 1'b1;
        tick();
        bus.ball_miss = 1'b0;
        check("miss1_lives",  32'(bus.lives), 32'd2);
        check("miss1_state",  32'(bus.state), 32'h0);
        check("miss1_reload", 32'(bus.ball_reload), 32'd1);
        check("miss1_bricks", 32'(bus.brick_map), 32'hFFFF);
        tick();
        check("miss1_reload_off", 32'(bus.ball_reload), 32'd0);
        bus.ball_miss = 1'b1;
        tick();
        bus.ball_miss = 1'b0;
        check("miss_in_serve_ignored", 32'(bus.lives), 32'd2);
        bus.throw = 1'b1;
        tick();
        bus.throw = 1'b0;
        tick();
        bus.ball_miss = 1'b1;
        tick();
        bus.ball_miss = 1'b0;
        check("miss2_lives",  32'(bus.lives), 32'd1);
        check("miss2_state",  32'(bus.state), 32'h0);
        check("miss2_reload", 32'(bus.ball_reload), 32'd1);
        bus.throw = 1'b1;
        tick();
        bus.throw = 1'b0;
        bus.ball_miss = 1'b1;
        tick();
        bus.ball_miss = 1'b0;
        check("miss3_lives",  32'(bus.lives), 32'd0);
        check("miss3_state",  32'(bus.state), 32'h2);
        check("miss3_reload", 32'(bus.ball_reload), 32'd0);
        check("over_hold",    32'(bus.hold_ball), 32'd1);

        // Restart from OVER
        tick();
        bus.throw = 1'b1;
        tick();
        check("over_restart_state",  32'(bus.state), 32'h0);
        check("over_restart_bricks", 32'(bus.brick_map), 32'hFFFF);
        check("over_restart_lives",  32'(bus.lives), 32'd3);
        check("over_restart_score",  32'(bus.score), 32'd0);
        check("over_restart_reload", 32'(bus.ball_reload), 32'd1);
        tick();
        tick();
        check("over_restart_held", 32'(bus.state), 32'h0);
        bus.throw = 1'b0;
        tick();

        // Reset in the cycle before a step is due
        bus.throw = 1'b1;
        tick();
        bus.throw = 1'b0;
        wait_step();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midplay_rst_step",  32'(bus.ball_step), 32'd0);
        check("midplay_rst_state", 32'(bus.state), 32'h0);
        check("midplay_rst_hold",  32'(bus.hold_ball), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
